// File: rtl/instr_sequencer_if.sv
// Host-bus and APU-control signal bundle for instr_sequencer.
// The slave modport is the sequencer's view; master is the host/APU side.
interface instr_sequencer_if #(
    parameter int P_INSTRUCTION_NUM = 16,
    parameter int P_INSTR_W         = 32,
    parameter int P_LOOP_W          = 8
);
    localparam int AW = $clog2(P_INSTRUCTION_NUM);

    logic                 nWe;
    logic [AW-1:0]        iWriteAddr;
    logic [P_INSTR_W-1:0] iWriteData;
    logic [AW-1:0]        iReadAddr;
    logic [P_INSTR_W-1:0] oWorkSheetData;
    logic [AW:0]          iProgLen;
    logic [P_LOOP_W-1:0]  iLoopCount;
    logic                 iAPUReady;
    logic                 iComputeDone;
    logic                 iAbort;
    logic [P_INSTR_W-1:0] oInstruction;
    logic                 oCtrlnCe;
    logic [AW-1:0]        oInstrIndex;
    logic                 oBusy;
    logic                 oWorkSheetDone;

    modport master (
        output nWe, iWriteAddr, iWriteData, iReadAddr,
        output iProgLen, iLoopCount, iAPUReady, iComputeDone, iAbort,
        input  oWorkSheetData, oInstruction, oCtrlnCe, oInstrIndex,
        input  oBusy, oWorkSheetDone
    );

    modport slave (
        input  nWe, iWriteAddr, iWriteData, iReadAddr,
        input  iProgLen, iLoopCount, iAPUReady, iComputeDone, iAbort,
        output oWorkSheetData, oInstruction, oCtrlnCe, oInstrIndex,
        output oBusy, oWorkSheetDone
    );
endinterface

// File: rtl/instr_sequencer.sv
// APU instruction sequencer: host-loaded instruction RAM issued in order, one entry per compute-done.
// Define SEQ_LOOP_EN to honour iLoopCount (program repeats iLoopCount+1 times); otherwise each start runs once.
//
// state | meaning
// IDLE  | waiting for iAPUReady, oCtrlnCe=1
// RUN   | oInstruction valid, advancing on iComputeDone
module instr_sequencer #(
    parameter int P_INSTRUCTION_NUM = 16,
    parameter int P_INSTR_W         = 32,
    parameter int P_LOOP_W          = 8
) (
    input  logic               clk,
    input  logic               nRst,
    instr_sequencer_if.slave   bus
);
    localparam int          AW     = $clog2(P_INSTRUCTION_NUM);
    localparam logic [AW:0] LP_NUM = (AW+1)'(P_INSTRUCTION_NUM);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t               r_state;
    logic [P_INSTR_W-1:0] r_ram [P_INSTRUCTION_NUM];
    logic [P_INSTR_W-1:0] r_rd_data;
    logic [P_INSTR_W-1:0] r_instr;
    logic                 r_nce;
    logic [AW-1:0]        r_idx;
    logic                 r_busy;
    logic                 r_done;
    logic [AW:0]          r_len;

    logic [AW:0]          w_len;
    logic [AW-1:0]        w_idx_next;
    logic                 w_last;
    logic                 w_loop_more;

    assign w_len      = (bus.iProgLen > LP_NUM) ? LP_NUM : bus.iProgLen;
    assign w_idx_next = r_idx + AW'(1);
    assign w_last     = (({1'b0, r_idx} + (AW+1)'(1)) == r_len);

`ifdef SEQ_LOOP_EN
    logic [P_LOOP_W-1:0] r_loops;
    logic                w_wrap;

    assign w_loop_more = (r_loops != '0);
    assign w_wrap      = (r_state == ST_RUN) && !bus.iAbort && bus.iComputeDone
                         && w_last && w_loop_more;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_loops <= '0;
        end else if ((r_state == ST_IDLE) && bus.iAPUReady) begin
            r_loops <= bus.iLoopCount;
        end else if (w_wrap) begin
            r_loops <= r_loops - P_LOOP_W'(1);
        end
    end
`else
    logic w_unused_loop;

    assign w_loop_more   = 1'b0;
    assign w_unused_loop = ^bus.iLoopCount;
`endif

    // RAM is deliberately not reset; writes land after the edge, so reads see old data.
    always_ff @(posedge clk) begin
        if (!bus.nWe && ({1'b0, bus.iWriteAddr} < LP_NUM)) begin
            r_ram[bus.iWriteAddr] <= bus.iWriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_rd_data <= '0;
        end else if ({1'b0, bus.iReadAddr} < LP_NUM) begin
            r_rd_data <= r_ram[bus.iReadAddr];
        end else begin
            r_rd_data <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
            r_nce   <= 1'b1;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_len   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.iAPUReady) begin
                        if (w_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_idx   <= '0;
                            r_instr <= r_ram[0];
                            r_nce   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_len   <= w_len;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.iAbort) begin
                        r_state <= ST_IDLE;
                        r_instr <= '0;
                        r_nce   <= 1'b1;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else if (bus.iComputeDone) begin
                        if (!w_last) begin
                            r_idx   <= w_idx_next;
                            r_instr <= r_ram[w_idx_next];
                        end else if (w_loop_more) begin
                            r_idx   <= '0;
                            r_instr <= r_ram[0];
                        end else begin
                            r_state <= ST_IDLE;
                            r_instr <= '0;
                            r_nce   <= 1'b1;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oWorkSheetData = r_rd_data;
    assign bus.oInstruction   = r_instr;
    assign bus.oCtrlnCe       = r_nce;
    assign bus.oInstrIndex    = r_idx;
    assign bus.oBusy          = r_busy;
    assign bus.oWorkSheetDone = r_done;
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised APU instruction sequencer, the successor to the fixed 16×32 worksheet. The host (bus slave side) loads a program into an internal instruction RAM. On APU-ready, the block issues the instructions in order to the control module, advancing one entry per compute-done. It adds an explicit program length, abort, an optional repeat loop, and a one-cycle completion pulse.

## Interface
- P_INSTRUCTION_NUM, 16, RAM depth; ≥2. AW = $clog2(P_INSTRUCTION_NUM).
- P_INSTR_W, 32, instruction/data width.
- P_LOOP_W, 8, repeat-count width.

- clk  in  1  single clock; all logic on rising edge.
- nRst  in  1  synchronous, active-low reset.
- nWe  in  1  active-low host write strobe.
- iWriteAddr  in  AW  host write address.
- iWriteData  in  P_INSTR_W  host write data.
- iReadAddr  in  AW  host readback address.
- oWorkSheetData  out  P_INSTR_W  readback data, registered.
- iProgLen  in  AW+1  program length, sampled at start.
- iLoopCount  in  P_LOOP_W  extra passes, sampled at start (SEQ_LOOP_EN only).
- iAPUReady  in  1  start request.
- iComputeDone  in  1  current instruction finished.
- iAbort  in  1  cancel the running program.
- oInstruction  out  P_INSTR_W  current instruction.
- oCtrlnCe  out  1  active-low: oInstruction is valid.
- oInstrIndex  out  AW  RAM index of oInstruction.
- oBusy  out  1  high in RUN.
- oWorkSheetDone  out  1  one-cycle completion pulse.

## Operation
- Reset values: oInstruction=0, oCtrlnCe=1, oInstrIndex=0, oBusy=0, oWorkSheetDone=0, oWorkSheetData=0. State is IDLE. RAM contents are not reset.
- Host write: when nWe=0, write iWriteData to RAM[iWriteAddr]. Writes are accepted in any state and ignored for addresses ≥ P_INSTRUCTION_NUM.
- Readback: oWorkSheetData <= RAM[iReadAddr] every cycle. Out-of-range addresses read 0. A same-cycle write and read to one address returns the old data.
- Length: len = min(iProgLen, P_INSTRUCTION_NUM).
- IDLE, iAPUReady=1, len=0: pulse oWorkSheetDone and stay in IDLE.
- IDLE, iAPUReady=1, len>0: go to RUN. Set idx=0, oInstruction=RAM[0], oCtrlnCe=0. Latch len and loops (= iLoopCount).
- RUN, iAbort=1: go to IDLE. Set oCtrlnCe=1, oInstruction=0, idx=0. No done pulse. Abort has priority over iComputeDone.
- RUN, iComputeDone=1, idx<len-1: idx+1, oInstruction=RAM[idx+1].
- RUN, iComputeDone=1, idx=len-1, loops>0: decrement loops, wrap to idx=0, oInstruction=RAM[0]. No gap cycle.
- RUN, iComputeDone=1, idx=len-1, loops=0: go to IDLE. Set oCtrlnCe=1, oInstruction=0, oWorkSheetDone=1 for exactly one cycle.
- RUN, no event: hold all outputs.
- iAPUReady is ignored in RUN. iComputeDone is ignored in IDLE.
- A write to the currently issued address does not change the held oInstruction. The new value is seen on the next fetch of that address.
- A write to idx+1 on the same edge as iComputeDone: the issued instruction is the old RAM value.

## Timing
- Start latency: iAPUReady sampled at edge N; oCtrlnCe=0 and oInstruction=RAM[0] are valid after edge N.
- Advance latency: iComputeDone sampled at edge N; the next instruction is valid after edge N. Minimum one cycle per instruction.
- oWorkSheetDone rises after the edge that samples the final iComputeDone and falls after the following edge.
- Back-to-back runs: iAPUReady held high restarts on the edge after the return to IDLE. The gap is exactly one cycle with oCtrlnCe=1.
- nRst=0 mid-run: all outputs take their reset values after the next edge. The program does not resume.

## Configuration
- SEQ_LOOP_EN defined: iLoopCount is honoured, and a program runs iLoopCount+1 times back-to-back.
- SEQ_LOOP_EN undefined: iLoopCount is ignored, loops is forced to 0, and each start runs the program exactly once. No loop counter is synthesised.

## Test plan
- Load RAM[0..3]=0xA0..0xA3, iProgLen=4, pulse iAPUReady, then 4 iComputeDone pulses 3 cycles apart. Expect oInstruction A0,A1,A2,A3, oInstrIndex 0..3, one oWorkSheetDone pulse, then oCtrlnCe=1 and oInstruction=0.
- iProgLen=0, iAPUReady=1 for one cycle. Expect an oWorkSheetDone pulse with oCtrlnCe staying 1. iProgLen=31 with depth 16: expect 16 instructions issued.
- SEQ_LOOP_EN, iProgLen=2, iLoopCount=2, iComputeDone held high. Expect the sequence 0,1,0,1,0,1 on consecutive cycles, then a single done pulse.
- Assert iAbort together with iComputeDone at idx=1 of 4. Expect IDLE next cycle, oCtrlnCe=1, no done pulse. A later start issues RAM[0].
- In RUN at idx=0, write 0x55 to RAM[1]. Expect oInstruction=0x55 after the next iComputeDone. Readback of address 1 returns 0x55 one cycle after the write.
- Assert nRst=0 for one cycle mid-run at idx=2. Expect reset values, then a fresh start from idx=0.
